// File: rtl/alloc_defs.sv
// Shared opcodes, reserved addresses and response record for the allocator front end.
package alloc_defs;

    typedef enum logic [1:0] {
        OP_ALLOC = 2'd0,
        OP_FREE  = 2'd1,
        OP_READ  = 2'd2,
        OP_WRITE = 2'd3
    } op_e;

    localparam logic [15:0] UNDEF    = 16'h0000;
    localparam logic [15:0] NIL      = 16'h0001;
    localparam logic [15:0] ERR_WORD = 16'hFFFF;

    typedef struct packed {
        logic valid;
        logic guard;
        op_e  op;
    } rec_t;

    // Address operands that can never name a live cell
    function automatic logic is_guarded(op_e op, logic [15:0] addr);
        return (op != OP_ALLOC) && ((addr == UNDEF) || (addr == NIL));
    endfunction

endpackage

// File: rtl/alloc_arb_grant.sv
// Two-client grant: read/write pairing across clients, otherwise
// round-robin between A and B on contention.
module alloc_arb_grant
    import alloc_defs::*;
(
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_en,
    input  logic        i_a_valid,
    input  logic        i_b_valid,
    input  op_e         i_a_op,
    input  op_e         i_b_op,
    input  logic [15:0] i_a_addr,
    input  logic [15:0] i_b_addr,
    output logic        o_gnt_a,
    output logic        o_gnt_b
);

    logic prio_b;
    logic both;
    logic rw_pair;
    logic pair;

    always_comb begin
        both    = i_a_valid && i_b_valid;
        rw_pair = ((i_a_op == OP_READ) && (i_b_op == OP_WRITE)) ||
                  ((i_a_op == OP_WRITE) && (i_b_op == OP_READ));
        pair    = both && rw_pair && (i_a_addr != i_b_addr);
        o_gnt_a = 1'b0;
        o_gnt_b = 1'b0;
        if (i_en) begin
            unique case (1'b1)
                pair: begin
                    o_gnt_a = 1'b1;
                    o_gnt_b = 1'b1;
                end
                both && !pair: begin
                    o_gnt_a = !prio_b;
                    o_gnt_b = prio_b;
                end
                i_a_valid && !i_b_valid: o_gnt_a = 1'b1;
                i_b_valid && !i_a_valid: o_gnt_b = 1'b1;
                default: ;
            endcase
        end
    end

    // A lone grant hands priority to the client that was not served
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            prio_b <= 1'b0;
        end else if (o_gnt_a ^ o_gnt_b) begin
            prio_b <= o_gnt_a;
        end
    end

endmodule

// File: rtl/alloc_arbiter.sv
// Two-client request front end for the linked-memory allocator.
// Optional build macro: ALLOC_ARB_GUARD_EN (reject UNDEF/NIL operands).
module alloc_arbiter
    import alloc_defs::*;
#(
    parameter int ADDR_SZ = 8
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_a_valid,
    output logic        o_a_ready,
    input  logic [1:0]  i_a_op,
    input  logic [15:0] i_a_addr,
    input  logic [15:0] i_a_data,
    output logic        o_a_resp,
    output logic [15:0] o_a_rdata,
    input  logic        i_b_valid,
    output logic        o_b_ready,
    input  logic [1:0]  i_b_op,
    input  logic [15:0] i_b_addr,
    input  logic [15:0] i_b_data,
    output logic        o_b_resp,
    output logic [15:0] o_b_rdata,
    output logic        o_alloc,
    output logic        o_free,
    output logic        o_rd,
    output logic        o_wr,
    output logic [15:0] o_data,
    output logic [15:0] o_addr,
    output logic [15:0] o_raddr,
    output logic [15:0] o_waddr,
    output logic [15:0] o_wdata,
    input  logic [15:0] i_alloc_addr,
    input  logic [15:0] i_alloc_rdata,
    input  logic        i_alloc_err,
    output logic        o_err
);

    localparam logic [15:0] AMASK = 16'((32'd1 << ADDR_SZ) - 32'd1);

    op_e  a_op;
    op_e  b_op;
    logic gnt_a;
    logic gnt_b;
    logic grd_a;
    logic grd_b;
    logic fwd_a;
    logic fwd_b;
    logic run;
    rec_t rec_a;
    rec_t rec_b;

    assign a_op = op_e'(i_a_op);
    assign b_op = op_e'(i_b_op);
    assign run  = i_rst_n && !o_err;

`ifdef ALLOC_ARB_GUARD_EN
    assign grd_a = is_guarded(a_op, i_a_addr);
    assign grd_b = is_guarded(b_op, i_b_addr);
`else
    assign grd_a = 1'b0;
    assign grd_b = 1'b0;
`endif

    alloc_arb_grant u_grant (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_en      (run),
        .i_a_valid (i_a_valid),
        .i_b_valid (i_b_valid),
        .i_a_op    (a_op),
        .i_b_op    (b_op),
        .i_a_addr  (i_a_addr),
        .i_b_addr  (i_b_addr),
        .o_gnt_a   (gnt_a),
        .o_gnt_b   (gnt_b)
    );

    assign o_a_ready = gnt_a;
    assign o_b_ready = gnt_b;
    assign fwd_a     = gnt_a && !grd_a;
    assign fwd_b     = gnt_b && !grd_b;

    // Pairing only ever mixes READ with WRITE, so no strobe has two drivers
    always_comb begin
        o_alloc = 1'b0;
        o_free  = 1'b0;
        o_rd    = 1'b0;
        o_wr    = 1'b0;
        o_data  = UNDEF;
        o_addr  = UNDEF;
        o_raddr = UNDEF;
        o_waddr = UNDEF;
        o_wdata = UNDEF;
        if (fwd_a) begin
            unique case (a_op)
                OP_ALLOC: begin
                    o_alloc = 1'b1;
                    o_data  = i_a_data;
                end
                OP_FREE: begin
                    o_free = 1'b1;
                    o_addr = i_a_addr;
                end
                OP_READ: begin
                    o_rd    = 1'b1;
                    o_raddr = i_a_addr;
                end
                OP_WRITE: begin
                    o_wr    = 1'b1;
                    o_waddr = i_a_addr;
                    o_wdata = i_a_data;
                end
            endcase
        end
        if (fwd_b) begin
            unique case (b_op)
                OP_ALLOC: begin
                    o_alloc = 1'b1;
                    o_data  = i_b_data;
                end
                OP_FREE: begin
                    o_free = 1'b1;
                    o_addr = i_b_addr;
                end
                OP_READ: begin
                    o_rd    = 1'b1;
                    o_raddr = i_b_addr;
                end
                OP_WRITE: begin
                    o_wr    = 1'b1;
                    o_waddr = i_b_addr;
                    o_wdata = i_b_data;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rec_a <= '0;
            rec_b <= '0;
            o_err <= 1'b0;
        end else begin
            rec_a <= '{valid: gnt_a, guard: grd_a, op: a_op};
            rec_b <= '{valid: gnt_b, guard: grd_b, op: b_op};
            o_err <= o_err | i_alloc_err | (gnt_a & grd_a) | (gnt_b & grd_b);
        end
    end

    function automatic logic [15:0] resp_word(rec_t r, logic [15:0] aaddr,
                                              logic [15:0] rdata);
        logic [15:0] w;
        w = UNDEF;
        if (r.guard) begin
            w = ERR_WORD;
        end else if (r.op == OP_ALLOC) begin
            w = aaddr & AMASK;
        end else if (r.op == OP_READ) begin
            w = rdata;
        end
        return w;
    endfunction

    // A rejected operand still reports back even though it raised o_err
    assign o_a_resp  = rec_a.valid && (!o_err || rec_a.guard);
    assign o_b_resp  = rec_b.valid && (!o_err || rec_b.guard);
    assign o_a_rdata = o_a_resp ? resp_word(rec_a, i_alloc_addr, i_alloc_rdata)
                                : UNDEF;
    assign o_b_rdata = o_b_resp ? resp_word(rec_b, i_alloc_addr, i_alloc_rdata)
                                : UNDEF;

endmodule

// File: tb/tb_alloc_arbiter.sv
// Bench for alloc_arbiter: directed vector table, corner sequences and
// randomized traffic against a cycle-level reference model.
module tb_alloc_arbiter;

    localparam int ADDR_SZ = 8;
`ifdef ALLOC_ARB_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    typedef struct packed {
        logic        av;
        logic [1:0]  aop;
        logic [15:0] aaddr;
        logic [15:0] adata;
        logic        bv;
        logic [1:0]  bop;
        logic [15:0] baddr;
        logic [15:0] bdata;
        logic [15:0] ia_addr;
        logic [15:0] ia_rdata;
        logic        aerr;
    } in_t;

    typedef struct packed {
        logic        ar;
        logic        br;
        logic        alloc;
        logic        free;
        logic        rd;
        logic        wr;
        logic [15:0] data;
        logic [15:0] addr;
        logic [15:0] raddr;
        logic [15:0] waddr;
        logic [15:0] wdata;
        logic        aresp;
        logic [15:0] ardata;
        logic        bresp;
        logic [15:0] brdata;
        logic        err;
    } obs_t;

    typedef struct {
        in_t         i;
        logic [39:0] e;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    in_t  cur = '0;

    logic        a_ready, b_ready, a_resp, b_resp;
    logic [15:0] a_rdata, b_rdata;
    logic        s_alloc, s_free, s_rd, s_wr, err;
    logic [15:0] s_data, s_addr, s_raddr, s_waddr, s_wdata;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    alloc_arbiter #(.ADDR_SZ(ADDR_SZ)) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_a_valid    (cur.av),
        .o_a_ready    (a_ready),
        .i_a_op       (cur.aop),
        .i_a_addr     (cur.aaddr),
        .i_a_data     (cur.adata),
        .o_a_resp     (a_resp),
        .o_a_rdata    (a_rdata),
        .i_b_valid    (cur.bv),
        .o_b_ready    (b_ready),
        .i_b_op       (cur.bop),
        .i_b_addr     (cur.baddr),
        .i_b_data     (cur.bdata),
        .o_b_resp     (b_resp),
        .o_b_rdata    (b_rdata),
        .o_alloc      (s_alloc),
        .o_free       (s_free),
        .o_rd         (s_rd),
        .o_wr         (s_wr),
        .o_data       (s_data),
        .o_addr       (s_addr),
        .o_raddr      (s_raddr),
        .o_waddr      (s_waddr),
        .o_wdata      (s_wdata),
        .i_alloc_addr (cur.ia_addr),
        .i_alloc_rdata(cur.ia_rdata),
        .i_alloc_err  (cur.aerr),
        .o_err        (err)
    );

    function automatic obs_t sample();
        obs_t o;
        o = '{a_ready, b_ready, s_alloc, s_free, s_rd, s_wr, s_data, s_addr,
              s_raddr, s_waddr, s_wdata, a_resp, a_rdata, b_resp, b_rdata, err};
        return o;
    endfunction

    task automatic chk(input string name, input logic [127:0] act,
                       input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Reference model: sticky error, round-robin owner, last-cycle grants
    int m_prio;
    bit m_err;
    bit pv[2];
    int pop[2];
    bit pg[2];
    bit mg[2];

    task automatic model_reset();
        m_prio = 0;
        m_err  = 1'b0;
        for (int c = 0; c < 2; c++) begin
            pv[c] = 1'b0;
            pop[c] = 0;
            pg[c] = 1'b0;
            mg[c] = 1'b0;
        end
    endtask

    task automatic model_cycle(input in_t x, output obs_t e);
        bit          v[2];
        int          op[2];
        logic [15:0] ad[2];
        logic [15:0] dt[2];
        bit          g[2];
        bit          gd[2];
        bit          rs[2];
        logic [15:0] rw[2];
        v[0] = x.av;  op[0] = int'(x.aop); ad[0] = x.aaddr; dt[0] = x.adata;
        v[1] = x.bv;  op[1] = int'(x.bop); ad[1] = x.baddr; dt[1] = x.bdata;
        e = '0;
        for (int c = 0; c < 2; c++) begin
            rs[c] = pv[c] && (!m_err || pg[c]);
            rw[c] = 16'h0000;
            if (rs[c]) begin
                if (pg[c]) rw[c] = 16'hFFFF;
                else if (pop[c] == 0) rw[c] = x.ia_addr;
                else if (pop[c] == 2) rw[c] = x.ia_rdata;
            end
            g[c] = 1'b0;
            gd[c] = 1'b0;
        end
        if (!m_err) begin
            if (v[0] && v[1]) begin
                if (op[0] + op[1] == 5 && ad[0] != ad[1]) begin
                    g[0] = 1'b1;
                    g[1] = 1'b1;
                end else begin
                    g[m_prio] = 1'b1;
                end
            end else begin
                g[0] = v[0];
                g[1] = v[1];
            end
        end
        for (int c = 0; c < 2; c++) begin
            if (g[c]) begin
                gd[c] = GUARD && op[c] != 0 && ad[c] < 16'd2;
                if (!gd[c]) begin
                    case (op[c])
                        0: begin e.alloc = 1'b1; e.data = dt[c]; end
                        1: begin e.free = 1'b1; e.addr = ad[c]; end
                        2: begin e.rd = 1'b1; e.raddr = ad[c]; end
                        default: begin
                            e.wr = 1'b1; e.waddr = ad[c]; e.wdata = dt[c];
                        end
                    endcase
                end
            end
        end
        e.ar = g[0];
        e.br = g[1];
        e.aresp = rs[0];
        e.ardata = rw[0];
        e.bresp = rs[1];
        e.brdata = rw[1];
        e.err = m_err;
        if (g[0] != g[1]) m_prio = g[0] ? 1 : 0;
        m_err = m_err | x.aerr | (g[0] & gd[0]) | (g[1] & gd[1]);
        for (int c = 0; c < 2; c++) begin
            pv[c] = g[c];
            pop[c] = op[c];
            pg[c] = gd[c];
            mg[c] = g[c];
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        cur = '0;
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    function automatic in_t mk(logic av, logic [1:0] aop, logic [15:0] aaddr,
                               logic [15:0] adata, logic bv, logic [1:0] bop,
                               logic [15:0] baddr, logic [15:0] bdata,
                               logic [15:0] ia, logic [15:0] ir);
        in_t x;
        x = '{av, aop, aaddr, adata, bv, bop, baddr, bdata, ia, ir, 1'b0};
        return x;
    endfunction

    function automatic logic [39:0] ex(logic ar, logic br, logic [3:0] stb,
                                       logic ars, logic [15:0] ard,
                                       logic brs, logic [15:0] brd);
        return {ar, br, stb, ars, ard, brs, brd};
    endfunction

    function automatic logic [15:0] rnd_addr();
        int p;
        p = int'($urandom_range(0, 39));
        if (p < 2) return 16'(p);
        if (p < 20) return 16'h0010 + 16'(p % 4);
        return 16'($urandom_range(2, 16'hFFFF));
    endfunction

    vec_t vecs[13];

    initial begin
        obs_t o;
        obs_t e;

        vecs[0]  = '{mk(1, 0, 0, 16'h00AA, 1, 1, 5, 0, 0, 0),
                     ex(1, 0, 4'b1000, 0, 0, 0, 0)};
        vecs[1]  = '{mk(0, 0, 0, 0, 1, 1, 5, 0, 16'h0002, 0),
                     ex(0, 1, 4'b0100, 1, 16'h0002, 0, 0)};
        vecs[2]  = '{mk(1, 2, 16'h10, 0, 1, 3, 16'h20, 16'h1234, 0, 0),
                     ex(1, 1, 4'b0011, 0, 0, 1, 0)};
        vecs[3]  = '{mk(1, 2, 16'h10, 0, 1, 3, 16'h10, 16'h7777, 0, 16'hBEEF),
                     ex(1, 0, 4'b0010, 1, 16'hBEEF, 1, 0)};
        vecs[4]  = '{mk(0, 0, 0, 0, 1, 3, 16'h10, 16'h7777, 0, 16'h5555),
                     ex(0, 1, 4'b0001, 1, 16'h5555, 0, 0)};
        vecs[5]  = '{mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 16'h9999),
                     ex(0, 0, 4'b0000, 0, 0, 1, 0)};
        vecs[6]  = '{mk(1, 3, 16'h30, 1, 1, 3, 16'h40, 2, 0, 0),
                     ex(1, 0, 4'b0001, 0, 0, 0, 0)};
        vecs[7]  = '{mk(0, 0, 0, 0, 1, 3, 16'h40, 2, 0, 0),
                     ex(0, 1, 4'b0001, 1, 0, 0, 0)};
        vecs[8]  = '{mk(1, 0, 0, 3, 1, 0, 0, 4, 0, 0),
                     ex(1, 0, 4'b1000, 0, 0, 1, 0)};
        vecs[9]  = '{mk(1, 0, 0, 5, 1, 0, 0, 4, 16'h0007, 0),
                     ex(0, 1, 4'b1000, 1, 16'h0007, 0, 0)};
        vecs[10] = '{mk(1, 0, 0, 5, 1, 0, 0, 6, 16'h0009, 0),
                     ex(1, 0, 4'b1000, 0, 0, 1, 16'h0009)};
        vecs[11] = '{mk(0, 0, 0, 0, 1, 0, 0, 6, 16'h0003, 0),
                     ex(0, 1, 4'b1000, 1, 16'h0003, 0, 0)};
        vecs[12] = '{mk(0, 0, 0, 0, 0, 0, 0, 0, 16'h0004, 0),
                     ex(0, 0, 4'b0000, 0, 0, 1, 16'h0004)};

        // Reset with an ALLOC pending, then first grant and its response
        rst_n = 1'b0;
        cur = mk(1, 0, 0, 16'h0042, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        #2 chk("rst_hold", 128'(sample()), 128'(0));
        rst_n = 1'b1;
        #1 o = sample();
        chk("rst_first_grant", {o.ar, o.alloc, o.data}, {2'b11, 16'h0042});
        @(negedge clk);
        cur.av = 1'b0;
        cur.ia_addr = 16'h0002;
        #2 o = sample();
        chk("rst_first_resp", {o.aresp, o.ardata}, {1'b1, 16'h0002});

        do_reset();
        foreach (vecs[i]) begin
            @(negedge clk);
            cur = vecs[i].i;
            #2 o = sample();
            chk($sformatf("vec%0d", i),
                {o.ar, o.br, o.alloc, o.free, o.rd, o.wr, o.aresp, o.ardata,
                 o.bresp, o.brdata}, vecs[i].e);
        end

        // Reset between grant and response drops the response
        do_reset();
        @(negedge clk);
        cur = mk(1, 0, 0, 16'h0011, 0, 0, 0, 0, 16'h0005, 0);
        @(posedge clk);
        #1 rst_n = 1'b0;
        cur.av = 1'b0;
        #1 chk("rst_mid_zero", 128'(sample()), 128'(0));
        @(negedge clk);
        rst_n = 1'b1;
        #2 o = sample();
        chk("rst_mid_noresp", {o.aresp, o.bresp, o.err}, 3'b000);

        // Sticky allocator error
        do_reset();
        @(negedge clk);
        cur.aerr = 1'b1;
        @(negedge clk);
        cur = mk(1, 0, 0, 1, 1, 2, 16'h20, 0, 0, 0);
        #2 chk("err_set", 128'(err), 128'(1));
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            #2 o = sample();
            chk($sformatf("err_hold%0d", k),
                {o.ar, o.br, o.alloc, o.free, o.rd, o.wr, o.aresp, o.bresp, o.err},
                9'b000000001);
        end
        do_reset();
        #2 chk("err_cleared", 128'(err), 128'(0));

        // READ of the NIL address
        @(negedge clk);
        cur = mk(0, 0, 0, 0, 1, 2, 16'h0001, 0, 0, 0);
        #2 o = sample();
        if (GUARD) chk("guard_nofwd", {o.br, o.rd, o.raddr}, {2'b10, 16'h0000});
        else chk("guard_fwd", {o.br, o.rd, o.raddr}, {2'b11, 16'h0001});
        @(negedge clk);
        cur.bv = 1'b0;
        cur.ia_rdata = 16'h4321;
        #2 o = sample();
        if (GUARD) chk("guard_resp", {o.bresp, o.brdata, o.err}, {1'b1, 16'hFFFF, 1'b1});
        else chk("guard_resp", {o.bresp, o.brdata, o.err}, {1'b1, 16'h4321, 1'b0});

        // Randomized traffic, clients hold requests until accepted
        for (int blk = 0; blk < 3; blk++) begin
            do_reset();
            for (int n = 0; n < 300; n++) begin
                @(negedge clk);
                if (!cur.av || mg[0]) begin
                    cur.av = ($urandom_range(0, 3) != 0);
                    cur.aop = 2'($urandom_range(0, 3));
                    cur.aaddr = rnd_addr();
                    cur.adata = 16'($urandom);
                end
                if (!cur.bv || mg[1]) begin
                    cur.bv = ($urandom_range(0, 3) != 0);
                    cur.bop = 2'($urandom_range(0, 3));
                    cur.baddr = rnd_addr();
                    cur.bdata = 16'($urandom);
                end
                cur.ia_addr = 16'($urandom_range(2, 255));
                cur.ia_rdata = 16'($urandom);
                cur.aerr = ($urandom_range(0, 199) == 0);
                #2 model_cycle(cur, e);
                chk($sformatf("rand%0d_%0d", blk, n), 128'(sample()), 128'(e));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

endmodule
